// File: rtl/ahb5_txn_arbiter_if.sv
// rtl/ahb5_txn_arbiter_if.sv - requester command/response and AHB5 manager signal bundle
// master modport: the arbiter (accepts commands, drives the AHB5 manager outputs).
// slave modport : the environment (requesters plus the AHB5 subordinate side).
interface ahb5_txn_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ-1:0][31:0] req_addr;
   logic [NUM_REQ-1:0]       req_write;
   logic [NUM_REQ-1:0][2:0]  req_size;
   logic [NUM_REQ-1:0][1:0]  req_len;
   logic [NUM_REQ-1:0][31:0] req_wdata;
   logic [NUM_REQ-1:0]       wdata_take;
   logic [NUM_REQ-1:0]       rsp_valid;
   logic [31:0]              rsp_rdata;
   logic                     rsp_err;
   logic                     rsp_last;

   logic                     HSEL;
   logic [31:0]              HADDR;
   logic                     HWRITE;
   logic [2:0]               HSIZE;
   logic [2:0]               HBURST;
   logic [3:0]               HPROT;
   logic [1:0]               HTRANS;
   logic [31:0]              HWDATA;
   logic                     HREADY;
   logic                     HRESP;
   logic [31:0]              HRDATA;

   modport master (
      input  req_valid, req_addr, req_write, req_size, req_len, req_wdata,
      input  HREADY, HRESP, HRDATA,
      output req_ready, wdata_take, rsp_valid, rsp_rdata, rsp_err, rsp_last,
      output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HWDATA
   );

   modport slave (
      output req_valid, req_addr, req_write, req_size, req_len, req_wdata,
      output HREADY, HRESP, HRDATA,
      input  req_ready, wdata_take, rsp_valid, rsp_rdata, rsp_err, rsp_last,
      input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HWDATA
   );
endinterface

// File: rtl/ahb5_txn_arbiter.sv
// rtl/ahb5_txn_arbiter.sv - multi-requester AHB5 manager front end with burst sequencing
// Ports:
//   HCLK   - clock
//   HRESET - asynchronous active-high reset
//   bus    - ahb5_txn_arbiter_if.master: per-requester command (req_*), write-beat
//            handshake (wdata_take), per-beat response (rsp_*) and the AHB5 manager port.
// Build option: define AHB5_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins);
// otherwise round-robin arbitration starting after the last winner.
module ahb5_txn_arbiter #(
   parameter int         NUM_REQ   = 2,
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input  logic                      HCLK,
   input  logic                      HRESET,
   ahb5_txn_arbiter_if.master        bus
);
   localparam int PTR_W = $clog2(NUM_REQ);

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   localparam logic [2:0] BU_SINGLE = 3'b000;
   localparam logic [2:0] BU_INCR   = 3'b001;
   localparam logic [2:0] BU_INCR4  = 3'b011;
   localparam logic [2:0] BU_INCR8  = 3'b101;
   localparam logic [2:0] BU_INCR16 = 3'b111;

   typedef enum logic [1:0] {ARB, XFER, TAIL, ERR} state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   owner_q, owner_d;
   logic               write_q, write_d;
   logic [3:0]         beat_q, beat_d;       // beat currently in address phase
   logic [3:0]         last_q, last_d;       // index of the final beat

   logic               hsel_q, hsel_d;
   logic [31:0]        haddr_q, haddr_d;
   logic               hwrite_q, hwrite_d;
   logic [2:0]         hsize_q, hsize_d;
   logic [2:0]         hburst_q, hburst_d;
   logic [3:0]         hprot_q, hprot_d;
   logic [1:0]         htrans_q, htrans_d;
   logic [31:0]        hwdata_q, hwdata_d;

   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [31:0]        rsp_rdata_q, rsp_rdata_d;
   logic               rsp_err_q, rsp_err_d;
   logic               rsp_last_q, rsp_last_d;

   logic [NUM_REQ-1:0] req_ready_c, wdata_take_c;
   logic               grant_any;
   logic [PTR_W-1:0]   grant_idx;
   logic [NUM_REQ-1:0] grant_oh, owner_oh;
   logic [31:0]        addr_inc;
   logic               launch;

`ifndef AHB5_ARB_FIXED_PRIO_EN
   logic [PTR_W-1:0]   rr_q, rr_d;
`endif

   // Winner selection, evaluated every cycle; only used when arbitration is open.
   always_comb begin
      int idx;
      idx       = 0;
      grant_any = 1'b0;
      grant_idx = '0;
`ifdef AHB5_ARB_FIXED_PRIO_EN
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (bus.req_valid[i]) begin
            grant_any = 1'b1;
            grant_idx = PTR_W'(i);
         end
      end
`else
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!grant_any && bus.req_valid[idx]) begin
            grant_any = 1'b1;
            grant_idx = PTR_W'(idx);
         end
      end
`endif
   end

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_oh[i] = (grant_idx == PTR_W'(i));
         owner_oh[i] = (owner_q == PTR_W'(i));
      end
   end

   assign addr_inc = haddr_q + (32'd1 << hsize_q);

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      write_d      = write_q;
      beat_d       = beat_q;
      last_d       = last_q;
      hsel_d       = hsel_q;
      haddr_d      = haddr_q;
      hwrite_d     = hwrite_q;
      hsize_d      = hsize_q;
      hburst_d     = hburst_q;
      hprot_d      = hprot_q;
      htrans_d     = htrans_q;
      hwdata_d     = hwdata_q;
      rsp_valid_d  = '0;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_err_d    = 1'b0;
      rsp_last_d   = 1'b0;
      req_ready_c  = '0;
      wdata_take_c = '0;
      launch       = 1'b0;
`ifndef AHB5_ARB_FIXED_PRIO_EN
      rr_d         = rr_q;
`endif

      case (state_q)
         ARB: begin
            if (grant_any) launch = 1'b1;
         end
         XFER: begin
            if (bus.HREADY) begin
               // Beats after the first overlap the previous beat's data phase.
               if (beat_q != 4'd0) begin
                  rsp_valid_d = owner_oh;
                  rsp_rdata_d = write_q ? 32'd0 : bus.HRDATA;
               end
               if (write_q) begin
                  hwdata_d     = bus.req_wdata[owner_q];
                  wdata_take_c = owner_oh;
               end
               if (beat_q == last_q) begin
                  htrans_d = TR_IDLE;
                  hsel_d   = 1'b0;
                  state_d  = TAIL;
               end else begin
                  beat_d  = beat_q + 4'd1;
                  haddr_d = addr_inc;
                  // Crossing a 1 KB page restarts the burst as undefined-length INCR.
                  if (addr_inc[9:0] == 10'd0) begin
                     htrans_d = TR_NONSEQ;
                     hburst_d = BU_INCR;
                  end else begin
                     htrans_d = TR_SEQ;
                  end
               end
            end else if (bus.HRESP && beat_q != 4'd0) begin
               // First ERROR cycle: cancel the pending address phase.
               htrans_d = TR_IDLE;
               hsel_d   = 1'b0;
               state_d  = ERR;
            end
         end
         TAIL: begin
            if (bus.HREADY) begin
               rsp_valid_d = owner_oh;
               rsp_rdata_d = write_q ? 32'd0 : bus.HRDATA;
               rsp_last_d  = 1'b1;
               state_d     = ARB;
               if (grant_any) launch = 1'b1;
            end else if (bus.HRESP) begin
               state_d = ERR;
            end
         end
         ERR: begin
            if (bus.HREADY) begin
               rsp_valid_d = owner_oh;
               rsp_rdata_d = 32'd0;
               rsp_err_d   = 1'b1;
               rsp_last_d  = 1'b1;
               state_d     = ARB;
            end
         end
         default: state_d = ARB;
      endcase

      // Accept the winner's command and put beat 0 on the bus next cycle.
      if (launch) begin
         req_ready_c = grant_oh;
         owner_d     = grant_idx;
         write_d     = bus.req_write[grant_idx];
         beat_d      = 4'd0;
         hsel_d      = 1'b1;
         haddr_d     = bus.req_addr[grant_idx];
         hwrite_d    = bus.req_write[grant_idx];
         hsize_d     = (bus.req_size[grant_idx] > 3'd2) ? 3'd2 : bus.req_size[grant_idx];
         htrans_d    = TR_NONSEQ;
         state_d     = XFER;
         case (bus.req_len[grant_idx])
            2'd0:    begin last_d = 4'd0;  hburst_d = BU_SINGLE; end
            2'd1:    begin last_d = 4'd3;  hburst_d = BU_INCR4;  end
            2'd2:    begin last_d = 4'd7;  hburst_d = BU_INCR8;  end
            default: begin last_d = 4'd15; hburst_d = BU_INCR16; end
         endcase
`ifndef AHB5_ARB_FIXED_PRIO_EN
         rr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
`endif
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q     <= ARB;
         owner_q     <= '0;
         write_q     <= 1'b0;
         beat_q      <= 4'd0;
         last_q      <= 4'd0;
         hsel_q      <= 1'b0;
         haddr_q     <= 32'd0;
         hwrite_q    <= 1'b0;
         hsize_q     <= 3'd0;
         hburst_q    <= 3'd0;
         hprot_q     <= HPROT_VAL;
         htrans_q    <= TR_IDLE;
         hwdata_q    <= 32'd0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
         rsp_last_q  <= 1'b0;
`ifndef AHB5_ARB_FIXED_PRIO_EN
         rr_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         write_q     <= write_d;
         beat_q      <= beat_d;
         last_q      <= last_d;
         hsel_q      <= hsel_d;
         haddr_q     <= haddr_d;
         hwrite_q    <= hwrite_d;
         hsize_q     <= hsize_d;
         hburst_q    <= hburst_d;
         hprot_q     <= hprot_d;
         htrans_q    <= htrans_d;
         hwdata_q    <= hwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         rsp_last_q  <= rsp_last_d;
`ifndef AHB5_ARB_FIXED_PRIO_EN
         rr_q        <= rr_d;
`endif
      end
   end

   assign bus.req_ready  = req_ready_c;
   assign bus.wdata_take = wdata_take_c;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_rdata  = rsp_rdata_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.rsp_last   = rsp_last_q;
   assign bus.HSEL       = hsel_q;
   assign bus.HADDR      = haddr_q;
   assign bus.HWRITE     = hwrite_q;
   assign bus.HSIZE      = hsize_q;
   assign bus.HBURST     = hburst_q;
   assign bus.HPROT      = hprot_q;
   assign bus.HTRANS     = htrans_q;
   assign bus.HWDATA     = hwdata_q;
endmodule

// File: tb/tb_ahb5_txn_arbiter.sv
// tb/tb_ahb5_txn_arbiter.sv - directed self-checking bench for ahb5_txn_arbiter
module tb_ahb5_txn_arbiter;
   localparam int N = 2;
   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] NONSEQ = 2'b10;
   localparam logic [1:0] SEQ    = 2'b11;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ahb5_txn_arbiter_if #(.NUM_REQ(N)) bus ();

   ahb5_txn_arbiter #(.NUM_REQ(N), .HPROT_VAL(4'b0011)) dut (
      .HCLK   (clk),
      .HRESET (rst),
      .bus    (bus.master)
   );

`ifdef AHB5_ARB_FIXED_PRIO_EN
   localparam logic [1:0] RR_G1 = 2'b01;
   localparam logic [31:0] RR_A1 = 32'h7000;
`else
   localparam logic [1:0] RR_G1 = 2'b10;
   localparam logic [31:0] RR_A1 = 32'h7100;
`endif

   task automatic test_reset();
      @(negedge clk); #1;
      checks++; if (bus.HTRANS !== IDLE) begin errors++; $display("FAIL reset_htrans got %h exp %h", bus.HTRANS, IDLE); end
      checks++; if (bus.HADDR !== 32'd0) begin errors++; $display("FAIL reset_haddr got %h exp 0", bus.HADDR); end
      checks++; if (bus.HSEL !== 1'b0) begin errors++; $display("FAIL reset_hsel got %b exp 0", bus.HSEL); end
      checks++; if (bus.HPROT !== 4'b0011) begin errors++; $display("FAIL reset_hprot got %h exp 3", bus.HPROT); end
      checks++; if (bus.HBURST !== 3'd0 || bus.HSIZE !== 3'd0 || bus.HWRITE !== 1'b0) begin errors++; $display("FAIL reset_ctrl got burst %h size %h write %b exp 0", bus.HBURST, bus.HSIZE, bus.HWRITE); end
      checks++; if (bus.HWDATA !== 32'd0) begin errors++; $display("FAIL reset_hwdata got %h exp 0", bus.HWDATA); end
      checks++; if (bus.rsp_valid !== 2'b00 || bus.rsp_last !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp got v %b l %b e %b d %h exp 0", bus.rsp_valid, bus.rsp_last, bus.rsp_err, bus.rsp_rdata); end
      checks++; if (bus.req_ready !== 2'b00 || bus.wdata_take !== 2'b00) begin errors++; $display("FAIL reset_ready got %b/%b exp 00", bus.req_ready, bus.wdata_take); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_single_read();
      @(negedge clk);
      bus.req_valid = 2'b01; bus.req_addr[0] = 32'h1000; bus.req_size[0] = 3'd2;
      bus.req_len[0] = 2'd0; bus.req_write[0] = 1'b0; #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", bus.req_ready); end
      @(negedge clk); bus.req_valid = 2'b00; #1;
      checks++; if (bus.HTRANS !== NONSEQ) begin errors++; $display("FAIL single_htrans got %h exp %h", bus.HTRANS, NONSEQ); end
      checks++; if (bus.HADDR !== 32'h1000) begin errors++; $display("FAIL single_haddr got %h exp 1000", bus.HADDR); end
      checks++; if (bus.HBURST !== 3'b000 || bus.HSEL !== 1'b1 || bus.HWRITE !== 1'b0 || bus.HSIZE !== 3'd2) begin errors++; $display("FAIL single_ctrl got burst %h sel %b write %b size %h", bus.HBURST, bus.HSEL, bus.HWRITE, bus.HSIZE); end
      checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL single_early_rsp got %b exp 00", bus.rsp_valid); end
      @(negedge clk); bus.HRDATA = 32'hDEADBEEF; #1;
      checks++; if (bus.HTRANS !== IDLE || bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL single_tail got trans %h rsp %b exp 0/00", bus.HTRANS, bus.rsp_valid); end
      @(negedge clk); bus.HRDATA = 32'd0; #1;
      checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL single_rsp_valid got %b exp 01", bus.rsp_valid); end
      checks++; if (bus.rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata got %h exp deadbeef", bus.rsp_rdata); end
      checks++; if (bus.rsp_last !== 1'b1 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL single_last got last %b err %b exp 1/0", bus.rsp_last, bus.rsp_err); end
   endtask

   task automatic test_incr4_write();
      logic [31:0] exp_addr [1:6];
      logic [1:0]  exp_trans [1:6];
      logic [31:0] exp_hw [2:6];
      logic        exp_take [1:6];
      logic        hr [1:6];
      logic        exp_rsp [1:7];
      int          takes = 0;
      exp_addr  = '{32'h2000, 32'h2004, 32'h2008, 32'h2008, 32'h200C, 32'h200C};
      exp_trans = '{NONSEQ, SEQ, SEQ, SEQ, SEQ, IDLE};
      exp_hw    = '{32'hA0, 32'hA1, 32'hA1, 32'hA2, 32'hA3};
      hr        = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      exp_take  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      exp_rsp   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      @(negedge clk);
      bus.req_valid = 2'b10; bus.req_addr[1] = 32'h2000; bus.req_size[1] = 3'd2;
      bus.req_len[1] = 2'd1; bus.req_write[1] = 1'b1; bus.req_wdata[1] = 32'hA0; #1;
      checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL wr_ready got %b exp 10", bus.req_ready); end
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         bus.req_valid = 2'b00;
         if (c <= 6) bus.HREADY = hr[c]; else bus.HREADY = 1'b1;
         #1;
         if (c <= 6) begin
            if (c <= 5) begin
               checks++; if (bus.HADDR !== exp_addr[c]) begin errors++; $display("FAIL wr_haddr c%0d got %h exp %h", c, bus.HADDR, exp_addr[c]); end
            end
            checks++; if (bus.HTRANS !== exp_trans[c]) begin errors++; $display("FAIL wr_htrans c%0d got %h exp %h", c, bus.HTRANS, exp_trans[c]); end
            checks++; if (bus.wdata_take[1] !== exp_take[c]) begin errors++; $display("FAIL wr_take c%0d got %b exp %b", c, bus.wdata_take[1], exp_take[c]); end
            if (c >= 2) begin
               checks++; if (bus.HWDATA !== exp_hw[c]) begin errors++; $display("FAIL wr_hwdata c%0d got %h exp %h", c, bus.HWDATA, exp_hw[c]); end
            end
            if (bus.wdata_take[1] === 1'b1) takes++;
         end
         checks++; if (bus.rsp_valid[1] !== exp_rsp[c]) begin errors++; $display("FAIL wr_rsp c%0d got %b exp %b", c, bus.rsp_valid[1], exp_rsp[c]); end
         checks++; if (bus.rsp_last !== (c == 7)) begin errors++; $display("FAIL wr_last c%0d got %b exp %b", c, bus.rsp_last, (c == 7)); end
         // Requester advances its data only after the beat was taken at the previous edge.
         if (bus.wdata_take[1] === 1'b1) begin
            @(posedge clk); #1; bus.req_wdata[1] = bus.req_wdata[1] + 32'd1;
         end
      end
      checks++; if (takes != 4) begin errors++; $display("FAIL wr_take_count got %0d exp 4", takes); end
   endtask

   task automatic test_round_robin();
      @(negedge clk);
      bus.req_valid = 2'b11; bus.req_write = 2'b00; bus.req_len[0] = 2'd0; bus.req_len[1] = 2'd0;
      bus.req_size[0] = 3'd2; bus.req_size[1] = 3'd2; bus.req_addr[0] = 32'h7000; bus.req_addr[1] = 32'h7100; #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rr_grant0 got %b exp 01", bus.req_ready); end
      @(negedge clk); #1;
      checks++; if (bus.HTRANS !== NONSEQ || bus.HADDR !== 32'h7000) begin errors++; $display("FAIL rr_addr0 got %h/%h exp %h/7000", bus.HTRANS, bus.HADDR, NONSEQ); end
      @(negedge clk); #1;
      checks++; if (bus.HTRANS !== IDLE) begin errors++; $display("FAIL rr_gap got %h exp %h", bus.HTRANS, IDLE); end
      checks++; if (bus.req_ready !== RR_G1) begin errors++; $display("FAIL rr_grant1 got %b exp %b", bus.req_ready, RR_G1); end
      @(negedge clk); #1;
      checks++; if (bus.HTRANS !== NONSEQ || bus.HADDR !== RR_A1) begin errors++; $display("FAIL rr_addr1 got %h/%h exp %h/%h", bus.HTRANS, bus.HADDR, NONSEQ, RR_A1); end
      checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_last !== 1'b1) begin errors++; $display("FAIL rr_rsp0 got %b/%b exp 01/1", bus.rsp_valid, bus.rsp_last); end
      @(negedge clk); #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rr_grant2 got %b exp 01", bus.req_ready); end
      @(negedge clk); @(negedge clk); #1;
      checks++; if (bus.req_ready !== RR_G1) begin errors++; $display("FAIL rr_grant3 got %b exp %b", bus.req_ready, RR_G1); end
      @(negedge clk); bus.req_valid = 2'b00;
      @(negedge clk); @(negedge clk); #1;
      checks++; if (bus.rsp_valid !== RR_G1 || bus.rsp_last !== 1'b1) begin errors++; $display("FAIL rr_rsp3 got %b/%b exp %b/1", bus.rsp_valid, bus.rsp_last, RR_G1); end
   endtask

   task automatic test_boundary();
      logic [31:0] ea;
      logic [1:0]  et;
      logic [2:0]  eb;
      int nrsp = 0;
      int last_at = 0;
      @(negedge clk);
      bus.req_valid = 2'b01; bus.req_addr[0] = 32'h3F8; bus.req_size[0] = 3'd2; bus.req_len[0] = 2'd2; #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL bnd_ready got %b exp 01", bus.req_ready); end
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk); bus.req_valid = 2'b00; bus.HRDATA = 32'h100 + c; #1;
         if (c <= 8) begin
            ea = 32'h3F8 + 32'(4 * (c - 1));
            et = (c == 1 || c == 3) ? NONSEQ : SEQ;
            eb = (c <= 2) ? 3'b101 : 3'b001;
            checks++; if (bus.HADDR !== ea) begin errors++; $display("FAIL bnd_haddr c%0d got %h exp %h", c, bus.HADDR, ea); end
            checks++; if (bus.HTRANS !== et) begin errors++; $display("FAIL bnd_htrans c%0d got %h exp %h", c, bus.HTRANS, et); end
            checks++; if (bus.HBURST !== eb) begin errors++; $display("FAIL bnd_hburst c%0d got %h exp %h", c, bus.HBURST, eb); end
         end
         if (c == 10) begin
            checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 32'h109) begin errors++; $display("FAIL bnd_last_rsp got %b/%h exp 01/109", bus.rsp_valid, bus.rsp_rdata); end
         end
         if (bus.rsp_valid[0] === 1'b1) begin
            nrsp++;
            if (bus.rsp_last === 1'b1) last_at = nrsp;
         end
      end
      bus.HRDATA = 32'd0;
      checks++; if (nrsp != 8) begin errors++; $display("FAIL bnd_rsp_count got %0d exp 8", nrsp); end
      checks++; if (last_at != 8) begin errors++; $display("FAIL bnd_last_pos got %0d exp 8", last_at); end
   endtask

   task automatic test_error();
      @(negedge clk);
      bus.req_valid = 2'b01; bus.req_addr[0] = 32'h5000; bus.req_size[0] = 3'd2; bus.req_len[0] = 2'd1; #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL err_ready got %b exp 01", bus.req_ready); end
      @(negedge clk); bus.req_valid = 2'b00;
      @(negedge clk); #1;
      checks++; if (bus.HADDR !== 32'h5004 || bus.HTRANS !== SEQ) begin errors++; $display("FAIL err_beat1 got %h/%h exp 5004/%h", bus.HADDR, bus.HTRANS, SEQ); end
      @(negedge clk); bus.HRESP = 1'b1; bus.HREADY = 1'b0; #1;
      checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL err_beat0_rsp got %b/%b exp 01/0", bus.rsp_valid, bus.rsp_err); end
      @(negedge clk); bus.HRESP = 1'b1; bus.HREADY = 1'b1; #1;
      checks++; if (bus.HTRANS !== IDLE || bus.HSEL !== 1'b0) begin errors++; $display("FAIL err_idle got %h/%b exp %h/0", bus.HTRANS, bus.HSEL, IDLE); end
      checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL err_wait_rsp got %b exp 00", bus.rsp_valid); end
      @(negedge clk); bus.HRESP = 1'b0; #1;
      checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_err !== 1'b1 || bus.rsp_last !== 1'b1) begin errors++; $display("FAIL err_rsp got %b/%b/%b exp 01/1/1", bus.rsp_valid, bus.rsp_err, bus.rsp_last); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         checks++; if (bus.HTRANS !== IDLE || bus.rsp_valid !== 2'b00 || bus.HADDR === 32'h500C) begin errors++; $display("FAIL err_after c%0d got %h/%b/%h exp idle/00", c, bus.HTRANS, bus.rsp_valid, bus.HADDR); end
      end
   endtask

   task automatic test_reset_midburst();
      @(negedge clk);
      bus.req_valid = 2'b01; bus.req_addr[0] = 32'h6000; bus.req_size[0] = 3'd2; bus.req_len[0] = 2'd3; #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rst_ready got %b exp 01", bus.req_ready); end
      @(negedge clk); bus.req_valid = 2'b00;
      @(negedge clk);
      @(negedge clk); #1;
      checks++; if (bus.HADDR !== 32'h6008 || bus.HTRANS !== SEQ) begin errors++; $display("FAIL rst_beat2 got %h/%h exp 6008/%h", bus.HADDR, bus.HTRANS, SEQ); end
      rst = 1'b1; #1;
      checks++; if (bus.HTRANS !== IDLE || bus.HADDR !== 32'd0 || bus.HSEL !== 1'b0 || bus.HBURST !== 3'd0 || bus.HSIZE !== 3'd0) begin errors++; $display("FAIL rst_bus got %h/%h/%b/%h/%h exp 0", bus.HTRANS, bus.HADDR, bus.HSEL, bus.HBURST, bus.HSIZE); end
      checks++; if (bus.rsp_valid !== 2'b00 || bus.HPROT !== 4'b0011 || bus.HWDATA !== 32'd0) begin errors++; $display("FAIL rst_misc got %b/%h/%h exp 00/3/0", bus.rsp_valid, bus.HPROT, bus.HWDATA); end
      @(negedge clk);
      bus.req_valid = 2'b11; bus.req_write = 2'b00;
      bus.req_addr[0] = 32'h8000; bus.req_size[0] = 3'd5; bus.req_len[0] = 2'd0;
      bus.req_addr[1] = 32'h8100; bus.req_size[1] = 3'd2; bus.req_len[1] = 2'd0;
      @(negedge clk); rst = 1'b0; #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rst_first_grant got %b exp 01", bus.req_ready); end
      @(negedge clk); bus.req_valid = 2'b00; #1;
      checks++; if (bus.HADDR !== 32'h8000 || bus.HSIZE !== 3'd2) begin errors++; $display("FAIL rst_new_cmd got %h/%h exp 8000/2", bus.HADDR, bus.HSIZE); end
      checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_no_rsp got %b exp 00", bus.rsp_valid); end
      @(negedge clk); @(negedge clk); #1;
      checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_last !== 1'b1) begin errors++; $display("FAIL rst_new_rsp got %b/%b exp 01/1", bus.rsp_valid, bus.rsp_last); end
   endtask

   initial begin
      bus.req_valid = '0; bus.req_addr = '0; bus.req_write = '0; bus.req_size = '0;
      bus.req_len = '0; bus.req_wdata = '0;
      bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = 32'd0;
      test_reset();
      test_single_read();
      test_incr4_write();
      test_round_robin();
      test_boundary();
      test_error();
      test_reset_midburst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
